// File: rtl/store_combine_buffer_if.sv
// Store buffer bus bundle: commit-side push, forwarding lookup and memory drain.
// The master drives stores, lookups and drain_ready; the slave is the buffer.
interface store_combine_buffer_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   localparam int BL = XLEN / 8;

   logic              push_valid;
   logic              push_ready;
   logic [ADDR_W-1:0] push_addr;
   logic [XLEN-1:0]   push_data;
   logic [BL-1:0]     push_be;

   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_fwd_valid;
   logic [XLEN-1:0]   ld_fwd_data;
   logic [BL-1:0]     ld_fwd_be;

   logic              drain_valid;
   logic              drain_ready;
   logic [ADDR_W-1:0] drain_addr;
   logic [XLEN-1:0]   drain_data;
   logic [BL-1:0]     drain_be;

   modport master (
      output push_valid, push_addr, push_data, push_be, ld_req, ld_addr, drain_ready,
      input  push_ready, ld_fwd_valid, ld_fwd_data, ld_fwd_be,
             drain_valid, drain_addr, drain_data, drain_be
   );

   modport slave (
      input  push_valid, push_addr, push_data, push_be, ld_req, ld_addr, drain_ready,
      output push_ready, ld_fwd_valid, ld_fwd_data, ld_fwd_be,
             drain_valid, drain_addr, drain_data, drain_be
   );
endinterface

// File: rtl/store_combine_buffer.sv
// Circular store combine buffer: byte-merging pushes, in-order drain, 1-cycle load forwarding.
// Optional SDB_STAT_EN adds saturating combine/allocate counters.
module store_combine_buffer #(
   parameter int SDB_NUM = 16,
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   store_combine_buffer_if.slave      bus,
   output logic [$clog2(SDB_NUM):0]   count,
   output logic                       empty,
   output logic                       full
`ifdef SDB_STAT_EN
   ,
   output logic [31:0]                stat_combine_cnt,
   output logic [31:0]                stat_alloc_cnt
`endif
);
   localparam int SDB_WIDTH = $clog2(SDB_NUM);
   localparam int BL        = XLEN / 8;
   localparam int OFF       = $clog2(BL);
   localparam int WA_W      = ADDR_W - OFF;

   typedef logic [SDB_WIDTH-1:0] idx_t;
   typedef logic [SDB_WIDTH:0]   ptr_t;

   logic [SDB_NUM-1:0] ent_valid;
   logic [WA_W-1:0]    ent_waddr [SDB_NUM];
   logic [XLEN-1:0]    ent_data  [SDB_NUM];
   logic [BL-1:0]      ent_be    [SDB_NUM];

   ptr_t head;
   ptr_t tail;
   idx_t head_idx;
   idx_t tail_idx;

   logic [WA_W-1:0]    push_wa;
   logic [WA_W-1:0]    ld_wa;
   logic               drain_vld;
   logic [SDB_NUM-1:0] cmb_hits;
   logic               cmb_hit;
   idx_t               cmb_idx;
   logic               push_fire;
   logic               do_combine;
   logic               do_alloc;
   logic               drain_fire;

   logic [SDB_NUM-1:0] lane_hits;
   logic [SDB_WIDTH:0] lane_sel;
   logic [BL-1:0]      fwd_be_n;
   logic [XLEN-1:0]    fwd_data_n;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.push_addr[OFF-1:0], bus.ld_addr[OFF-1:0]};

   // Binary tree of 2:1 pickers; the winner is the hit farthest from head (youngest).
   function automatic logic [SDB_WIDTH:0] pick_youngest(input logic [SDB_NUM-1:0] hits,
                                                        input idx_t hd);
      logic [SDB_NUM-1:0] h;
      idx_t               ix [SDB_NUM];
      idx_t               age_a;
      idx_t               age_b;
      h = hits;
      for (int i = 0; i < SDB_NUM; i++) ix[i] = idx_t'(i);
      for (int l = 0; l < SDB_WIDTH; l++) begin
         for (int j = 0; j < (SDB_NUM >> (l + 1)); j++) begin
            age_a = ix[2*j] - hd;
            age_b = ix[2*j+1] - hd;
            if (h[2*j+1] && (!h[2*j] || age_b > age_a)) ix[j] = ix[2*j+1];
            else                                         ix[j] = ix[2*j];
            h[j] = h[2*j] | h[2*j+1];
         end
      end
      return {h[0], ix[0]};
   endfunction

   assign head_idx = head[SDB_WIDTH-1:0];
   assign tail_idx = tail[SDB_WIDTH-1:0];
   assign empty    = (head == tail);
   assign full     = (head_idx == tail_idx) && (head[SDB_WIDTH] != tail[SDB_WIDTH]);
   assign count    = tail - head;
   assign push_wa  = bus.push_addr[ADDR_W-1:OFF];
   assign ld_wa    = bus.ld_addr[ADDR_W-1:OFF];

   assign drain_vld       = !empty;
   assign bus.drain_valid = drain_vld;
   assign bus.drain_addr  = {ent_waddr[head_idx], {OFF{1'b0}}};
   assign bus.drain_data  = ent_data[head_idx];
   assign bus.drain_be    = ent_be[head_idx];

   // The head may be leaving this cycle, so it never takes new bytes.
   always_comb begin
      cmb_hits = '0;
      for (int i = 0; i < SDB_NUM; i++) begin
         cmb_hits[i] = ent_valid[i] && (ent_waddr[i] == push_wa)
                       && !(drain_vld && (idx_t'(i) == head_idx));
      end
      {cmb_hit, cmb_idx} = pick_youngest(cmb_hits, head_idx);
   end

   assign bus.push_ready = cmb_hit | !full;
   assign push_fire      = bus.push_valid & bus.push_ready;
   assign do_combine     = push_fire & cmb_hit;
   assign do_alloc       = push_fire & !cmb_hit;
   assign drain_fire     = drain_vld & bus.drain_ready;

   always_comb begin
      fwd_be_n   = '0;
      fwd_data_n = '0;
      lane_hits  = '0;
      lane_sel   = '0;
      for (int b = 0; b < BL; b++) begin
         for (int i = 0; i < SDB_NUM; i++) begin
            lane_hits[i] = ent_valid[i] && (ent_waddr[i] == ld_wa) && ent_be[i][b];
         end
         lane_sel    = pick_youngest(lane_hits, head_idx);
         fwd_be_n[b] = lane_sel[SDB_WIDTH];
         if (lane_sel[SDB_WIDTH]) begin
            fwd_data_n[b*8 +: 8] = ent_data[lane_sel[SDB_WIDTH-1:0]][b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
         head      <= '0;
         tail      <= '0;
         for (int i = 0; i < SDB_NUM; i++) begin
            ent_waddr[i] <= '0;
            ent_data[i]  <= '0;
            ent_be[i]    <= '0;
         end
      end else begin
         if (do_alloc) begin
            ent_valid[tail_idx] <= 1'b1;
            ent_waddr[tail_idx] <= push_wa;
            ent_data[tail_idx]  <= bus.push_data;
            ent_be[tail_idx]    <= bus.push_be;
            tail                <= tail + ptr_t'(1);
         end
         if (do_combine) begin
            for (int b = 0; b < BL; b++) begin
               if (bus.push_be[b]) ent_data[cmb_idx][b*8 +: 8] <= bus.push_data[b*8 +: 8];
            end
            ent_be[cmb_idx] <= ent_be[cmb_idx] | bus.push_be;
         end
         if (drain_fire) begin
            ent_valid[head_idx] <= 1'b0;
            head                <= head + ptr_t'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ld_fwd_valid <= 1'b0;
         bus.ld_fwd_data  <= '0;
         bus.ld_fwd_be    <= '0;
      end else begin
         bus.ld_fwd_valid <= bus.ld_req;
         bus.ld_fwd_data  <= bus.ld_req ? fwd_data_n : '0;
         bus.ld_fwd_be    <= bus.ld_req ? fwd_be_n : '0;
      end
   end

`ifdef SDB_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_combine_cnt <= '0;
         stat_alloc_cnt   <= '0;
      end else begin
         if (do_combine && (stat_combine_cnt != 32'hFFFF_FFFF))
            stat_combine_cnt <= stat_combine_cnt + 32'd1;
         if (do_alloc && (stat_alloc_cnt != 32'hFFFF_FFFF))
            stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
      end
   end
`endif

endmodule
